// File: rtl/demux1x8.sv
// 1-to-8 demultiplexer: routes 'in' to the output selected by {s2,s1,s0};
// every other output is held low.
module demux1x8 (
  input  logic       in,
  input  logic       s0,
  input  logic       s1,
  input  logic       s2,
  output logic [7:0] out
);

  always_comb begin
    out = '0;
    out[{s2, s1, s0}] = in;
  end

endmodule

// File: rtl/demux_1x8_deser.sv
// Serial-to-parallel byte assembler.
// A 3-bit select drives a 1x8 demux whose outputs are per-bit accumulator write enables.
module demux_1x8_deser #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d,
  input  logic       d_valid,
  input  logic       clear,
  input  logic       y_ready,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       overrun
);

  localparam int NUM_BITS = 8;
  localparam logic [2:0] LAST_SEL = 3'(NUM_BITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] y_q, y_d;
  logic       y_valid_q, y_valid_d;
  logic       overrun_q, overrun_d;

  logic       sample;
  logic       byte_done;
  logic [2:0] lane;
  logic [7:0] bit_we;
  logic [7:0] acc_new;

  // A clear cycle swallows any d_valid on the same edge.
  assign sample    = d_valid & ~clear;
  assign byte_done = sample && (sel_q == LAST_SEL);
  // MSB-first order writes bit 7-sel, which is simply the inverted select.
  assign lane      = LSB_FIRST ? sel_q : ~sel_q;

  demux1x8 u_demux (
    .in  (sample),
    .s0  (lane[0]),
    .s1  (lane[1]),
    .s2  (lane[2]),
    .out (bit_we)
  );

  always_comb begin
    acc_new = acc_q;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (bit_we[i]) acc_new[i] = d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE:    if (sample) state_d = FILL;
      FILL:    if (byte_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d   = IDLE;
      sel_d     = '0;
      acc_d     = '0;
      overrun_d = 1'b0;
    end else if (sample) begin
      sel_d = sel_q + 3'd1;
      acc_d = acc_new;
    end

    // Output register is independent of the accumulator; a full byte arriving
    // while the previous one is still unconsumed is dropped and flagged.
    if (byte_done) begin
      if (!y_valid_q || y_ready) begin
        y_d       = acc_new;
        y_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign s0      = sel_q[0];
  assign s1      = sel_q[1];
  assign s2      = sel_q[2];
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_demux_1x8_deser.sv
// Directed bench for demux_1x8_deser; LSB-first and MSB-first instances share stimulus.
module tb_demux_1x8_deser;

  logic clk = 1'b0;
  logic rst_n;
  logic d, d_valid, clear, y_ready;

  logic       s0_l, s1_l, s2_l, yv_l, ov_l;
  logic [7:0] y_l;
  logic       s0_m, s1_m, s2_m, yv_m, ov_m;
  logic [7:0] y_m;

  logic [2:0] sel_l, sel_m;
  assign sel_l = {s2_l, s1_l, s0_l};
  assign sel_m = {s2_m, s1_m, s0_m};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_1x8_deser #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .clear(clear),
    .y_ready(y_ready), .s0(s0_l), .s1(s1_l), .s2(s2_l), .y(y_l),
    .y_valid(yv_l), .overrun(ov_l)
  );

  demux_1x8_deser #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .clear(clear),
    .y_ready(y_ready), .s0(s0_m), .s1(s1_m), .s2(s2_m), .y(y_m),
    .y_valid(yv_m), .overrun(ov_m)
  );

  // Drives val[0] first; returns at the negedge after the 8th bit is captured.
  task automatic send_byte(input logic [7:0] val, input logic rdy);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      d = val[i];
      d_valid = 1'b1;
      y_ready = rdy;
    end
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; d = 0; d_valid = 0; clear = 0; y_ready = 0;
    #12;
    checks++;
    if ({sel_l, y_l, yv_l, ov_l} !== 13'd0) begin
      errors++; $display("[TB] FAIL reset_lsb: got %b, required 0", {sel_l, y_l, yv_l, ov_l});
    end
    checks++;
    if ({sel_m, y_m, yv_m, ov_m} !== 13'd0) begin
      errors++; $display("[TB] FAIL reset_msb: got %b, required 0", {sel_m, y_m, yv_m, ov_m});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_byte();
    logic [7:0] bits;
    bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 7) begin
        checks++;
        if (yv_l !== 1'b0) begin
          errors++; $display("[TB] FAIL early_valid: got %b, required 0", yv_l);
        end
      end
      d = bits[i]; d_valid = 1'b1; y_ready = 1'b1;
    end
    @(negedge clk);
    d_valid = 1'b0;
    checks++;
    if (yv_l !== 1'b1 || y_l !== 8'h4D) begin
      errors++; $display("[TB] FAIL lsb_byte: got v=%b y=%h, required v=1 y=4d", yv_l, y_l);
    end
    checks++;
    if (yv_m !== 1'b1 || y_m !== 8'hB2) begin
      errors++; $display("[TB] FAIL msb_byte: got v=%b y=%h, required v=1 y=b2", yv_m, y_m);
    end
    @(negedge clk);
    checks++;
    if (yv_l !== 1'b0 || y_l !== 8'h4D) begin
      errors++; $display("[TB] FAIL valid_one_cycle: got v=%b y=%h, required v=0 y=4d", yv_l, y_l);
    end
    y_ready = 1'b0;
  endtask

  task automatic test_overrun();
    send_byte(8'hA5, 1'b0);
    checks++;
    if (yv_l !== 1'b1 || y_l !== 8'hA5 || ov_l !== 1'b0) begin
      errors++; $display("[TB] FAIL first_hold: got v=%b y=%h ov=%b, required 1 a5 0", yv_l, y_l, ov_l);
    end
    send_byte(8'h3C, 1'b0);
    checks++;
    if (yv_l !== 1'b1 || y_l !== 8'hA5 || ov_l !== 1'b1) begin
      errors++; $display("[TB] FAIL overrun_set: got v=%b y=%h ov=%b, required 1 a5 1", yv_l, y_l, ov_l);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d = 1'b1; d_valid = 1'b1;
    end
    @(negedge clk);
    d_valid = 1'b0;
    checks++;
    if (sel_l !== 3'd3) begin
      errors++; $display("[TB] FAIL partial_sel: got %0d, required 3", sel_l);
    end
    clear = 1'b1; d_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0; d_valid = 1'b0;
    checks++;
    if (ov_l !== 1'b0 || sel_l !== 3'd0 || yv_l !== 1'b1 || y_l !== 8'hA5) begin
      errors++; $display("[TB] FAIL clear: got ov=%b sel=%0d v=%b y=%h, required 0 0 1 a5", ov_l, sel_l, yv_l, y_l);
    end
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    checks++;
    if (yv_l !== 1'b0) begin
      errors++; $display("[TB] FAIL drain: got v=%b, required 0", yv_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] second;
    second = 8'h80;
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (yv_l !== 1'b1 || y_l !== 8'h01) begin
        errors++; $display("[TB] FAIL b2b_hold%0d: got v=%b y=%h, required 1 01", i, yv_l, y_l);
      end
      d = second[i]; d_valid = 1'b1; y_ready = (i == 7);
    end
    @(negedge clk);
    d_valid = 1'b0;
    checks++;
    if (yv_l !== 1'b1 || y_l !== 8'h80 || ov_l !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_second: got v=%b y=%h ov=%b, required 1 80 0", yv_l, y_l, ov_l);
    end
    checks++;
    if (y_m !== 8'h01) begin
      errors++; $display("[TB] FAIL b2b_msb: got %h, required 01", y_m);
    end
    @(negedge clk);
    y_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d = 1'b1; d_valid = 1'b1;
    end
    @(negedge clk);
    d_valid = 1'b0;
    checks++;
    if (sel_l !== 3'd4) begin
      errors++; $display("[TB] FAIL pre_reset_sel: got %0d, required 4", sel_l);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel_l, y_l, yv_l, ov_l} !== 13'd0) begin
      errors++; $display("[TB] FAIL async_reset: got %b, required 0", {sel_l, y_l, yv_l, ov_l});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hFF, 1'b0);
    checks++;
    if (yv_l !== 1'b1 || y_l !== 8'hFF || y_m !== 8'hFF || sel_l !== 3'd0) begin
      errors++; $display("[TB] FAIL post_reset_byte: got v=%b y=%h ym=%h sel=%0d, required 1 ff ff 0", yv_l, y_l, y_m, sel_l);
    end
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
  endtask

  task automatic test_gaps();
    logic [7:0] val;
    val = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (sel_l !== 3'(i)) begin
        errors++; $display("[TB] FAIL gap_sel%0d: got %0d, required %0d", i, sel_l, i);
      end
      d = val[i]; d_valid = 1'b1;
      @(negedge clk);
      d_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (yv_l !== 1'b1 || y_l !== 8'h5A || sel_l !== 3'd0 || ov_l !== 1'b0) begin
      errors++; $display("[TB] FAIL gap_byte: got v=%b y=%h sel=%0d ov=%b, required 1 5a 0 0", yv_l, y_l, sel_l, ov_l);
    end
  endtask

  initial begin
    test_reset();
    test_basic_byte();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1x8_deser.md
DEMUX_1X8_DESER -- requirements
Module: demux_1x8_deser

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1, meaning: 1 routes the first serial bit to y[0], 0 routes it to y[7].
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port d  input  1  serial data bit.
REQ-005 SHALL have port d_valid  input  1  d is sampled on this cycle.
REQ-006 SHALL have port clear  input  1  synchronous restart: drops partial byte, clears overrun.
REQ-007 SHALL have port y_ready  input  1  consumer accepts y this cycle.
REQ-008 SHALL have port s0, s1, s2  output  1 each  current demux select (bit index 0..7 of next sample; s0 = LSB).
REQ-009 SHALL have port y  output  8  assembled parallel byte.
REQ-010 SHALL have port y_valid  output  1  y holds an unconsumed byte.
REQ-011 SHALL have port overrun  output  1  sticky: a completed byte was discarded.

Function
REQ-012 SHALL keep a 3-bit select counter {s2,s1,s0} that advances by 1 on each cycle with d_valid=1 and wraps from 7 to 0.
REQ-013 SHALL write d into accumulator bit sel (LSB_FIRST=1) or bit 7-sel (LSB_FIRST=0) on each d_valid cycle; other bits unchanged.
REQ-014 SHALL use FSM states IDLE (sel=0, no partial byte), FILL (1..7 bits held), with output state tracked by y_valid.
REQ-015 SHALL transition IDLE->FILL on d_valid, FILL->IDLE when the 8th bit (sel=7) is accepted, and any state->IDLE on clear.
REQ-016 SHALL, on the cycle the 8th bit is accepted, copy the completed byte (including that bit) into y and set y_valid the next cycle: latency 1 clock from 8th d_valid edge to y_valid=1.
REQ-017 SHALL hold y and y_valid stable while y_valid=1 and y_ready=0.
REQ-018 SHALL clear y_valid on a cycle with y_valid=1 and y_ready=1; y keeps its last value.
REQ-019 SHALL, when a byte completes in the same cycle y_valid=1 and y_ready=1, load the new byte into y and keep y_valid=1 (no bubble, no overrun).
REQ-020 SHALL, when a byte completes while y_valid=1 and y_ready=0, discard the new byte, keep y unchanged, and set overrun=1.
REQ-021 SHALL keep accepting serial bits while y_valid=1 (accumulator independent of y).
REQ-022 SHALL, on clear=1, set sel=0, zero the accumulator, clear overrun, and ignore d_valid that cycle; y and y_valid unaffected.
REQ-023 SHALL ignore y_ready when y_valid=0.

Reset
REQ-024 SHALL on rst_n=0, asynchronously force s0=s1=s2=0, accumulator=8'h00, y=8'h00, y_valid=0, overrun=0, FSM=IDLE.
REQ-025 SHALL, on reset mid-byte, discard the partial byte; first d_valid after release lands at select 0.

Structure
REQ-026 SHALL need no shared package; the bit-count constant 8 and FSM state encodings are localparams in the module.
REQ-027 SHALL instantiate one sub-module demux1x8 (combinational: in, s0, s1, s2 -> 8 one-hot-gated outputs) to generate per-bit write enables for the accumulator.

Verification
REQ-028 SHALL check: reset, then 8 d_valid bits 1,0,1,1,0,0,1,0 with LSB_FIRST=1, y_ready=1 -> y=8'h4D, y_valid high for exactly 1 cycle, one clock after the 8th bit.
REQ-029 SHALL check: same bits with LSB_FIRST=0 -> y=8'hB2.
REQ-030 SHALL check: y_ready=0, two full bytes 8'hA5 then 8'h3C -> y stays 8'hA5, overrun=1 after second byte; clear -> overrun=0, sel=0.
REQ-031 SHALL check: back-to-back bytes 8'h01, 8'h80 with y_ready=1 on completion cycle -> y_valid stays 1 continuously, y shows 8'h01 then 8'h80, overrun=0.
REQ-032 SHALL check: 4 bits sent, rst_n pulsed low asynchronously mid-cycle -> all outputs 0 immediately; next 8 bits 8'hFF -> y=8'hFF.
REQ-033 SHALL check: d_valid gaps (valid every 3rd cycle) for byte 8'h5A -> {s2,s1,s0} advances only on valid cycles, y=8'h5A.
